// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode, ALUop, forwarding-select encodings and the bubble constant shared by the control pipeline
package ctrl_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_CMP   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  typedef struct packed {
    logic       valid;
    logic [1:0] aluop;
    logic       alusrc;
    logic       branch;
    logic       jump;
    logic       memread;
    logic       memwrite;
    logic       memtoreg;
    logic       regwrite;
  } ctrl_t;
  localparam ctrl_t BUBBLE = '0;
endpackage

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: combinational stall and operand-forwarding select; scheme chosen by CTRL_PIPE_FORWARDING_EN
module hazard_fwd_unit
  import ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              id_valid,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              redir,
  input  logic              ex_valid,
  input  logic              ex_memread,
  input  logic              ex_regwrite,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic              mem_valid,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_valid,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  output logic              stall_o,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);
  function automatic logic hit(input logic v, input logic w, input logic [REG_AW-1:0] rd);
    return id_valid & v & w & (rd != '0) & ((id_use_rs1 & (id_rs1 == rd)) | (id_use_rs2 & (id_rs2 == rd)));
  endfunction
`ifdef CTRL_PIPE_FORWARDING_EN
  function automatic logic [1:0] src(input logic [REG_AW-1:0] rs);
    return (mem_valid & mem_regwrite & (mem_rd != '0) & (mem_rd == rs)) ? FWD_MEM :
           (wb_valid & wb_regwrite & (wb_rd != '0) & (wb_rd == rs)) ? FWD_WB : FWD_RF;
  endfunction
  logic unused_fwd;
  assign unused_fwd = ex_regwrite;
  assign stall_o = !redir & hit(ex_valid, ex_memread, ex_rd);
  assign fwd_a = src(ex_rs1);
  assign fwd_b = src(ex_rs2);
`else
  logic unused_nofwd;
  assign unused_nofwd = ^{ex_memread, ex_rs1, ex_rs2, wb_valid, wb_regwrite, wb_rd};
  assign stall_o = !redir & (hit(ex_valid, ex_regwrite, ex_rd) | hit(mem_valid, mem_regwrite, mem_rd));
  assign fwd_a = FWD_RF;
  assign fwd_b = FWD_RF;
`endif
endmodule

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: ID/EX, EX/MEM, MEM/WB control registers with hazard stall, redirect flush and forwarding selects (CTRL_PIPE_FORWARDING_EN enables forwarding)
module ctrl_pipeline
  import ctrl_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [1:0]        id_aluop,
  input  logic              id_alusrc,
  input  logic              id_branch,
  input  logic              id_jump,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,
  input  logic              id_regwrite,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_redirect,
  output logic              stall_o,
  output logic              flush_ifid,
  output logic              ex_valid,
  output logic [1:0]        ex_aluop,
  output logic              ex_alusrc,
  output logic              ex_branch,
  output logic              ex_jump,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_memtoreg,
  output logic              ex_regwrite,
  output logic [REG_AW-1:0] ex_rd,
  output logic              mem_valid,
  output logic              mem_memread,
  output logic              mem_memwrite,
  output logic              mem_memtoreg,
  output logic              mem_regwrite,
  output logic [REG_AW-1:0] mem_rd,
  output logic              wb_valid,
  output logic              wb_memtoreg,
  output logic              wb_regwrite,
  output logic [REG_AW-1:0] wb_rd,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);
  ctrl_t id_c, ex_c;
  logic [REG_AW-1:0] ex_rs1, ex_rs2;
  logic redir, take;
  assign redir = ex_redirect & ex_valid;
  assign flush_ifid = redir;
  assign take = id_valid & !stall_o & !redir;
  assign id_c = {1'b1, id_aluop, id_alusrc, id_branch, id_jump, id_memread, id_memwrite, id_memtoreg, id_regwrite};
  assign {ex_valid, ex_aluop, ex_alusrc, ex_branch, ex_jump, ex_memread, ex_memwrite, ex_memtoreg, ex_regwrite} = ex_c;
  // ID/EX: accept the ID instruction, or insert a bubble on stall, redirect or empty ID
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ex_c   <= BUBBLE;
      ex_rd  <= '0;
      ex_rs1 <= '0;
      ex_rs2 <= '0;
    end else begin
      ex_c   <= take ? id_c : BUBBLE;
      ex_rd  <= take ? id_rd : '0;
      ex_rs1 <= (take & id_use_rs1) ? id_rs1 : '0;
      ex_rs2 <= (take & id_use_rs2) ? id_rs2 : '0;
    end
  // EX/MEM and MEM/WB: advance every cycle, no back-pressure
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_valid    <= 1'b0;
      mem_memread  <= 1'b0;
      mem_memwrite <= 1'b0;
      mem_memtoreg <= 1'b0;
      mem_regwrite <= 1'b0;
      mem_rd       <= '0;
      wb_valid     <= 1'b0;
      wb_memtoreg  <= 1'b0;
      wb_regwrite  <= 1'b0;
      wb_rd        <= '0;
    end else begin
      mem_valid    <= ex_valid;
      mem_memread  <= ex_memread;
      mem_memwrite <= ex_memwrite;
      mem_memtoreg <= ex_memtoreg;
      mem_regwrite <= ex_regwrite;
      mem_rd       <= ex_rd;
      wb_valid     <= mem_valid;
      wb_memtoreg  <= mem_memtoreg;
      wb_regwrite  <= mem_regwrite;
      wb_rd        <= mem_rd;
    end
  hazard_fwd_unit #(.REG_AW(REG_AW)) u_hfu (
    .id_valid     (id_valid),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .redir        (redir),
    .ex_valid     (ex_valid),
    .ex_memread   (ex_memread),
    .ex_regwrite  (ex_regwrite),
    .ex_rd        (ex_rd),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .mem_valid    (mem_valid),
    .mem_regwrite (mem_regwrite),
    .mem_rd       (mem_rd),
    .wb_valid     (wb_valid),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .stall_o      (stall_o),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
  );
endmodule
